sbox_stream_converter: RTL and testbench

SBOX_STREAM_CONVERTER -- requirements
Module: sbox_stream_converter

---
 rtl/sbox_conv_pkg.sv | 50 +++++
 rtl/sbox_lane.sv | 18 +
 rtl/sbox_stream_converter.sv | 99 +++++++++
 tb/tb_sbox_stream_converter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_conv_pkg.sv
// Shared constants for the S-box stream converter: byte type, defaults and the
// forward/inverse AES substitution tables.
package sbox_conv_pkg;

    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;
    localparam int PIPE_DEFAULT   = 2;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t sbox_table_t [256];

    localparam sbox_table_t SBOX_FWD = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam sbox_table_t SBOX_INV = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single byte lane: forward or inverse AES S-box, or pass-through when disabled.
module sbox_lane
    import sbox_conv_pkg::*;
(
    input  byte_t din,
    input  logic  dec,
    input  logic  en,
    output byte_t dout
);

    always_comb begin
        dout = din;
        if (en) begin
            dout = dec ? SBOX_INV[din] : SBOX_FWD[din];
        end
    end

endmodule

// File: rtl/sbox_stream_converter.sv
// Valid/ready stream of byte beats through per-lane S-box substitution, followed
// by a PIPE-deep elastic register pipeline where each beat carries its own mode.
module sbox_stream_converter
    import sbox_conv_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int PIPE   = PIPE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_dec,
    input  logic [NBYTES-1:0]          in_mask,
    input  logic [BYTE_W*NBYTES-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_dec,
    output logic [BYTE_W*NBYTES-1:0]   out_data,
    output logic [$clog2(PIPE+1)-1:0]  inflight
);

    localparam int DATA_W = BYTE_W * NBYTES;
    localparam int CNT_W  = $clog2(PIPE + 1);

    logic              valid_reg [PIPE];
    logic              dec_reg   [PIPE];
    logic [DATA_W-1:0] data_reg  [PIPE];
    logic [PIPE-1:0]   stage_load;
    logic [DATA_W-1:0] sub_data;
    logic [CNT_W-1:0]  count;

    genvar gi;
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
        sbox_lane u_lane (
            .din  (in_data[BYTE_W*gi +: BYTE_W]),
            .dec  (in_dec),
            .en   (in_mask[gi]),
            .dout (sub_data[BYTE_W*gi +: BYTE_W])
        );
    end

    // Walk from the output back to stage 0: a stage may load when it is empty
    // or its occupant moves on, which lets bubbles collapse under a stall.
    always_comb begin
        logic ready_below;
        ready_below = out_ready;
        stage_load  = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            stage_load[k] = !valid_reg[k] || ready_below;
            ready_below   = stage_load[k];
        end
    end

    assign in_ready = !rst && stage_load[0];

    for (gi = 0; gi < PIPE; gi++) begin : g_stage
        logic              src_valid;
        logic              src_dec;
        logic [DATA_W-1:0] src_data;

        if (gi == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_dec   = in_dec;
            assign src_data  = sub_data;
        end else begin : g_body
            assign src_valid = valid_reg[gi-1];
            assign src_dec   = dec_reg[gi-1];
            assign src_data  = data_reg[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                dec_reg[gi]   <= 1'b0;
                data_reg[gi]  <= '0;
            end else if (stage_load[gi]) begin
                valid_reg[gi] <= src_valid;
                if (src_valid) begin
                    dec_reg[gi]  <= src_dec;
                    data_reg[gi] <= src_data;
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < PIPE; k++) begin
            count = count + CNT_W'(valid_reg[k]);
        end
    end

    assign inflight  = count;
    assign out_valid = valid_reg[PIPE-1];
    assign out_dec   = dec_reg[PIPE-1];
    assign out_data  = data_reg[PIPE-1];

endmodule

// File: tb/tb_sbox_stream_converter.sv
// Directed and randomly throttled stimulus for sbox_stream_converter; expected beats
// come from a GF(2^8) reference S-box and are queued at acceptance.
module tb_sbox_stream_converter;

    localparam int NB   = 4;
    localparam int PIPE = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        dec;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_dec;
    logic [3:0]  in_mask;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_dec;
    logic [31:0] out_data;
    logic [1:0]  inflight;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;
    beat_t sb_q[$];
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    sbox_stream_converter #(.NBYTES(NB), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_data  (out_data),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic beat_t model(input logic [31:0] d, input logic dec, input logic [3:0] m);
        beat_t r;
        r.dec  = dec;
        r.data = d;
        for (int i = 0; i < NB; i++) begin
            if (m[i]) r.data[8*i +: 8] = dec ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake-level behaviour, score the output, record the input.
    task automatic tick();
        beat_t e;
        #1;
        check("in_ready", 64'(in_ready), 64'(!rst && (sb_q.size() < PIPE || out_ready)));
        check("inflight", 64'(inflight), 64'(sb_q.size()));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_beat", 64'(out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_dec", 64'(out_dec), 64'(e.dec));
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(in_data, in_dec, in_mask));
            accepted++;
            $display("accept #%0d data=%08h dec=%0b mask=%h", accepted, in_data, in_dec, in_mask);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic dec, input logic [3:0] m);
        in_valid = v; in_data = d; in_dec = dec; in_mask = m;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("drain_left", 64'(sb_q.size()), 64'(0));
        check("drain_inflight", 64'(inflight), 64'(0));
    endtask

    initial begin
        logic [7:0] inv;
        beat_t held;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        rst = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'hdead_beef, 1'b0, 4'hf);
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_dec", 64'(out_dec), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        #1 check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Forward latency
        drive(1'b1, 32'hff53_0100, 1'b0, 4'hf);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        check("lat_not_yet", 64'(out_valid), 64'(0));
        tick();
        check("lat_valid", 64'(out_valid), 64'(1));
        check("fwd_data", 64'(out_data), 64'h16ed_7c63);
        tick();

        // Back-to-back forward then inverse beats
        drive(1'b1, 32'hff53_0100, 1'b0, 4'hf); tick();
        drive(1'b1, 32'h16ed_7c63, 1'b1, 4'hf); tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        check("b2b_first", 64'(out_data), 64'h16ed_7c63);
        check("b2b_first_dec", 64'(out_dec), 64'(0));
        tick();
        check("b2b_second_valid", 64'(out_valid), 64'(1));
        check("inv_data", 64'(out_data), 64'hff53_0100);
        check("inv_dec", 64'(out_dec), 64'(1));
        tick();

        // Partial mask
        drive(1'b1, 32'h0000_0000, 1'b0, 4'h5); tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0); tick();
        check("mask_data", 64'(out_data), 64'h0063_0063);
        drain();

        // Backpressure: fill, hold, release
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1020_3040 + 32'(i * 32'h0101_0101), 1'(i), 4'hf);
            tick();
        end
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_inflight", 64'(inflight), 64'(PIPE));
        held = sb_q[0];
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(held.data));
            check("hold_dec", 64'(out_dec), 64'(held.dec));
        end
        drain();

        // Random throttling
        begin
            int start;
            start = accepted;
            for (int cyc = 0; cyc < 20000 && accepted - start < 1000; cyc++) begin
                drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                out_ready = 1'($urandom_range(0, 2) != 0);
                tick();
                check("inflight_bound", 64'(inflight <= PIPE), 64'(1));
            end
            check("random_count", 64'(accepted - start >= 1000), 64'(1));
        end
        drain();

        // Mid-stream reset
        out_ready = 1'b0;
        drive(1'b1, 32'hcafe_f00d, 1'b1, 4'hf); tick();
        drive(1'b1, 32'h0bad_cafe, 1'b0, 4'ha); tick();
        check("pre_rst_inflight", 64'(inflight), 64'(2));
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_inflight", 64'(inflight), 64'(0));
        sb_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_stale", 64'(out_valid), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
